// File: rtl/mmac_operand_loader_pkg.sv
// Shared sizes, loader state encoding and packing helper for the MMAC operand loader.
package mmac_operand_loader_pkg;
  localparam int M_SIZE     = 4;
  localparam int VAR_WIDTH  = 8;
  localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH;
  localparam int ELEMS      = M_SIZE * M_SIZE;
  localparam int IDX_W      = $clog2(ELEMS);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} loader_state_t;

  // Bit offset of element [r][c] inside a packed matrix (row-major).
  function automatic int pack_idx(input int r, input int c);
    return (r * M_SIZE + c) * VAR_WIDTH;
  endfunction
endpackage

// File: rtl/mmac_operand_loader_if.sv
// Element-stream input and packed-pair output of the operand loader.
interface mmac_operand_loader_if;
  logic                                          in_valid;
  logic                                          in_ready;
  logic [mmac_operand_loader_pkg::VAR_WIDTH-1:0]  in_data;
  logic                                          mat_valid;
  logic                                          mat_ready;
  logic [mmac_operand_loader_pkg::DATA_WIDTH-1:0] matrixA;
  logic [mmac_operand_loader_pkg::DATA_WIDTH-1:0] matrixB;
  logic                                          mat_first;
  logic [7:0]                                    group_cnt;

  modport slave (
    input  in_valid, in_data, mat_ready,
    output in_ready, mat_valid, matrixA, matrixB, mat_first, group_cnt
  );

  modport master (
    output in_valid, in_data, mat_ready,
    input  in_ready, mat_valid, matrixA, matrixB, mat_first, group_cnt
  );
endinterface

// File: rtl/mmac_operand_loader_bank.sv
// One A/B operand register pair: element write port, packed read buses.
module mmac_operand_bank
  import mmac_operand_loader_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  we_i,
  input  logic                  sel_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [VAR_WIDTH-1:0]  data_i,
  output logic [DATA_WIDTH-1:0] mat_a_o,
  output logic [DATA_WIDTH-1:0] mat_b_o
);
  logic [ELEMS-1:0][VAR_WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else if (we_i) begin
      if (sel_i) b_q[idx_i] <= data_i;
      else       a_q[idx_i] <= data_i;
    end
  end

  for (genvar r = 0; r < M_SIZE; r++) begin : g_row
    for (genvar c = 0; c < M_SIZE; c++) begin : g_col
      assign mat_a_o[pack_idx(r, c) +: VAR_WIDTH] = a_q[r*M_SIZE+c];
      assign mat_b_o[pack_idx(r, c) +: VAR_WIDTH] = b_q[r*M_SIZE+c];
    end
  end
endmodule

// File: rtl/mmac_operand_loader.sv
// Assembles an A/B operand pair from an element stream and hands it to the MMAC.
// Define MMAC_LOADER_DBUF_EN for ping-pong banks (load next pair while presenting).
module mmac_operand_loader
  import mmac_operand_loader_pkg::*;
#(
  parameter int ACC_DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  clear,
  mmac_operand_loader_if.slave bus
);
`ifdef MMAC_LOADER_DBUF_EN
  localparam int NBANK = 2;
  localparam loader_state_t AFTER_B = LOAD_A;
`else
  localparam int NBANK = 1;
  localparam loader_state_t AFTER_B = PRESENT;
`endif

  loader_state_t                    state_q;
  logic [IDX_W-1:0]                 elem_q;
  logic [7:0]                       pair_q, pair_nxt;
  logic                             mat_valid_q;
  logic                             in_ready, acc, last_elem, last_b, hs;
  logic [NBANK-1:0]                 bank_we;
  logic [NBANK-1:0][DATA_WIDTH-1:0] bank_a, bank_b;

  assign acc       = bus.in_valid && in_ready;
  assign last_elem = (elem_q == IDX_W'(ELEMS - 1));
  assign last_b    = acc && (state_q == LOAD_B) && last_elem;
  assign hs        = mat_valid_q && bus.mat_ready;
  assign pair_nxt  = (pair_q == 8'(ACC_DEPTH - 1)) ? 8'd0 : pair_q + 8'd1;

`ifdef MMAC_LOADER_DBUF_EN
  logic       fill_q, pres_q;
  logic [1:0] full_q, full_d;

  // full_q counts completed pairs not yet handed off (0..2).
  assign full_d   = full_q + {1'b0, last_b} - {1'b0, hs};
  assign in_ready = !clear && (full_q != 2'd2);
  assign bank_we  = {acc && fill_q, acc && !fill_q};
  assign bus.matrixA = bank_a[pres_q];
  assign bus.matrixB = bank_b[pres_q];
`else
  assign in_ready = !clear && (state_q != PRESENT);
  assign bank_we  = acc;
  assign bus.matrixA = bank_a[0];
  assign bus.matrixB = bank_b[0];
`endif

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state_q     <= LOAD_A;
      elem_q      <= '0;
      pair_q      <= '0;
      mat_valid_q <= 1'b0;
`ifdef MMAC_LOADER_DBUF_EN
      fill_q      <= 1'b0;
      pres_q      <= 1'b0;
      full_q      <= '0;
`endif
    end else begin
      if (acc) begin
        elem_q <= last_elem ? '0 : elem_q + 1'b1;
        if (last_elem) state_q <= (state_q == LOAD_A) ? LOAD_B : AFTER_B;
      end
`ifdef MMAC_LOADER_DBUF_EN
      if (last_b) fill_q <= !fill_q;
      if (hs) begin
        pres_q <= !pres_q;
        pair_q <= pair_nxt;
      end
      // A finishing fill and a handoff in the same cycle keep mat_valid high.
      full_q      <= full_d;
      mat_valid_q <= (full_d != 2'd0);
`else
      if (last_b) mat_valid_q <= 1'b1;
      if (hs) begin
        state_q     <= LOAD_A;
        mat_valid_q <= 1'b0;
        pair_q      <= pair_nxt;
      end
`endif
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    mmac_operand_bank u_bank (
      .clock_i  (clock),
      .reset_ni (reset),
      .we_i     (bank_we[b]),
      .sel_i    (state_q == LOAD_B),
      .idx_i    (elem_q),
      .data_i   (bus.in_data),
      .mat_a_o  (bank_a[b]),
      .mat_b_o  (bank_b[b])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.mat_valid = mat_valid_q;
  assign bus.mat_first = mat_valid_q && (pair_q == 8'd0);
  assign bus.group_cnt = pair_q;
endmodule

// File: tb/tb_mmac_operand_loader.sv
// Randomized bench for mmac_operand_loader against a queue-based pair model.
`timescale 1ns/1ps
module tb_mmac_operand_loader;
  import mmac_operand_loader_pkg::*;

  localparam int ACC        = 4;
  localparam int PAIR_BEATS = 2 * ELEMS;
`ifdef MMAC_LOADER_DBUF_EN
  localparam int NBUF   = 2;
  localparam int PERIOD = 2 * ELEMS;
`else
  localparam int NBUF   = 1;
  localparam int PERIOD = 2 * ELEMS + 1;
`endif

  typedef logic [DATA_WIDTH-1:0] wv_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  mmac_operand_loader_if bus();

  mmac_operand_loader #(.ACC_DEPTH(ACC)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: accepted beats accumulate; every 32 form a pair appended to the expected queue.
  logic [VAR_WIDTH-1:0] beats[$];
  wv_t expA[$], expB[$];
  wv_t ma, mb;
  int  pairs_out = 0;
  bit  mon_en = 0;
  bit  tput = 0;
  int  cyc = 0;
  int  last_hs = 0;
  int  hs_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready", wv_t'(bus.in_ready), wv_t'(!clear && (expA.size() < NBUF)));
      chk("mat_valid", wv_t'(bus.mat_valid), wv_t'(expA.size() != 0));
      if (bus.mat_valid && expA.size() != 0) begin
        chk("matrixA", bus.matrixA, expA[0]);
        chk("matrixB", bus.matrixB, expB[0]);
        chk("mat_first", wv_t'(bus.mat_first), wv_t'(pairs_out % ACC == 0));
        chk("group_cnt", wv_t'(bus.group_cnt), wv_t'(pairs_out % ACC));
      end
      if (!reset || clear) begin
        beats.delete();
        expA.delete();
        expB.delete();
        pairs_out = 0;
      end else begin
        if (bus.mat_valid && bus.mat_ready && expA.size() != 0) begin
          void'(expA.pop_front());
          void'(expB.pop_front());
          pairs_out++;
          if (tput) begin
            if (hs_cnt > 0) chk("hs_period", wv_t'(cyc - last_hs), wv_t'(PERIOD));
            hs_cnt++;
            last_hs = cyc;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          beats.push_back(bus.in_data);
          if (beats.size() == PAIR_BEATS) begin
            for (int i = 0; i < ELEMS; i++) begin
              ma[i*VAR_WIDTH +: VAR_WIDTH] = beats[i];
              mb[i*VAR_WIDTH +: VAR_WIDTH] = beats[ELEMS+i];
            end
            expA.push_back(ma);
            expB.push_back(mb);
            beats.delete();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one beat and hold it until it is taken (bounded).
  task automatic beat(input logic [VAR_WIDTH-1:0] d);
    bit ok = 0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && n < 500) begin
      @(negedge clock);
      ok = bus.in_ready && reset && !clear;
      tick();
      n++;
    end
    if (!ok) chk("beat_timeout", wv_t'(ok), wv_t'(1));
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) beat(VAR_WIDTH'($urandom));
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = VAR_WIDTH'($urandom);
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    @(negedge clock);
    chk({tag, "_mA"}, bus.matrixA, '0);
    chk({tag, "_mB"}, bus.matrixB, '0);
    chk({tag, "_first"}, wv_t'(bus.mat_first), '0);
    chk({tag, "_grp"}, wv_t'(bus.group_cnt), '0);
    chk({tag, "_rdy"}, wv_t'(bus.in_ready), wv_t'(1));
    chk({tag, "_vld"}, wv_t'(bus.mat_valid), '0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mat_ready = 1'b0;
    reset = 1'b0;
    tick();
    mon_en = 1;
    repeat (2) tick();
    reset = 1'b1;
    reset_vals("rst");

    // Directed pair: A = 1..16, B = 16..1
    bus.mat_ready = 1'b1;
    for (int i = 1; i <= ELEMS; i++) beat(VAR_WIDTH'(i));
    for (int i = ELEMS; i >= 1; i--) beat(VAR_WIDTH'(i));
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("dir_vld", wv_t'(bus.mat_valid), wv_t'(1));
    chk("dir_a_lo", wv_t'(bus.matrixA[7:0]), wv_t'(1));
    chk("dir_a_hi", wv_t'(bus.matrixA[127:120]), wv_t'(16));
    chk("dir_b_lo", wv_t'(bus.matrixB[7:0]), wv_t'(16));
    chk("dir_first", wv_t'(bus.mat_first), wv_t'(1));
    chk("dir_grp", wv_t'(bus.group_cnt), '0);
    tick();

    // Back-pressure: hold the pair for 10 cycles, then a single handshake
    bus.mat_ready = 1'b0;
    rand_beats(PAIR_BEATS);
    repeat (10) tick();
    bus.mat_ready = 1'b1;
    tick();
    bus.mat_ready = 1'b0;
    repeat (2) tick();

    // Five consecutive pairs from a fresh group
    pulse_clear();
    bus.mat_ready = 1'b1;
    rand_beats(5 * PAIR_BEATS);
    repeat (3) tick();

    // Clear mid-load, then clear while a pair is presented
    rand_beats(20);
    pulse_clear();
    rand_beats(PAIR_BEATS);
    repeat (3) tick();
    bus.mat_ready = 1'b0;
    rand_beats(PAIR_BEATS);
    tick();
    pulse_clear();
    bus.mat_ready = 1'b1;
    rand_beats(PAIR_BEATS);
    repeat (3) tick();

    // One-cycle reset in the middle of loading B, beat offered on that cycle
    rand_beats(20);
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = VAR_WIDTH'($urandom);
    tick();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    reset_vals("rst_mid");
    rand_beats(PAIR_BEATS);
    repeat (3) tick();

    // Random traffic with occasional clears
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = VAR_WIDTH'($urandom);
      bus.mat_ready = ($urandom_range(2) != 0);
      clear         = ($urandom_range(199) == 0);
      tick();
    end
    clear = 1'b0;
    bus.in_valid = 1'b0;

    // Streaming at full rate: handshake spacing
    pulse_clear();
    hs_cnt = 0;
    tput = 1;
    bus.mat_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 330; i++) begin
      bus.in_data = VAR_WIDTH'($urandom);
      tick();
    end
    tput = 0;
    bus.in_valid = 1'b0;
    chk("tput_hs_cnt", wv_t'(hs_cnt >= 8), wv_t'(1));
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmac_operand_loader.md
Name: mmac_operand_loader

Overview:
- Upstream feeder for the matrix multiply stage.
- Accepts a narrow element stream with a valid/ready handshake and assembles one M_SIZE x M_SIZE operand pair (matrix A, then matrix B).
- Presents each completed pair as packed matrixA/matrixB buses with a valid/ready handshake.
- Tags each pair so the downstream accumulator knows when to clear.

Parameters:
- ACC_DEPTH, 4: operand pairs per accumulation group. mat_first marks pair 0 of each group. Legal range 1..255.
- ELEM_W, VAR_WIDTH (mmac_pkg): width of one matrix element.
- MAT_W, DATA_WIDTH (mmac_pkg): width of one packed matrix. Equals M_SIZE*M_SIZE*ELEM_W.

Ports:
- clock  in  1  Single clock. All logic on the rising edge.
- reset  in  1  Synchronous, active-low reset.
- clear  in  1  Synchronous abort. Drops any partial or held pair and restarts the group count.
- in_valid  in  1  Element beat valid.
- in_ready  out  1  Loader can accept a beat.
- in_data  in  ELEM_W  Element value. Row-major order, all of A then all of B.
- mat_valid  out  1  Packed pair available.
- mat_ready  in  1  Downstream accepts the pair.
- matrixA  out  MAT_W  Packed A. Element [r][c] at bit offset ((r*M_SIZE+c)*ELEM_W).
- matrixB  out  MAT_W  Packed B. Same packing as A.
- mat_first  out  1  Qualified by mat_valid. This pair starts a new accumulation group.
- group_cnt  out  8  Index of the presented pair within its group, 0..ACC_DEPTH-1.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to LOAD_A; elem_cnt=0; pair_cnt=0.
  - in_ready=1, mat_valid=0, mat_first=0, group_cnt=0.
  - matrixA and matrixB are zeroed.
  - Reset mid-transfer discards all partial data. No beat is accepted on the reset cycle.
- A beat is accepted when in_valid && in_ready on a rising edge. It writes the element at elem_cnt of the bank being loaded.
- State machine (base build):
  - LOAD_A:
    - Accept beats into A; elem_cnt increments on each accepted beat.
    - On the accepted beat with elem_cnt==M_SIZE*M_SIZE-1: set elem_cnt=0 and go to LOAD_B.
  - LOAD_B:
    - Same as LOAD_A, filling B.
    - On the last B beat go to PRESENT.
    - mat_valid rises the cycle after the last B beat is accepted (1-cycle latency).
  - PRESENT:
    - in_ready=0 (base build).
    - mat_valid=1. matrixA, matrixB, mat_first and group_cnt are held stable until the pair is accepted.
    - On mat_valid && mat_ready: go to LOAD_A and update pair_cnt (increment; wrap to 0 after ACC_DEPTH-1).
- Output encoding:
  - mat_first = (pair_cnt==0).
  - group_cnt = pair_cnt.
- mat_valid must never drop without a handshake, except on reset or clear.
- clear (takes priority over the handshake in the same cycle):
  - Go to LOAD_A; elem_cnt=0; pair_cnt=0; mat_valid=0.
  - A beat offered on a clear cycle is not accepted (in_ready is forced to 0 that cycle).
  - Packed output contents are don't-care once mat_valid=0.
- in_data is not interpreted arithmetically. No width conversion or sign handling.
- Throughput (base build): one pair per 2*M_SIZE*M_SIZE + 1 cycles at best.

Optional Feature:
- Macro: MMAC_LOADER_DBUF_EN.
- Defined (two A/B bank pairs, ping-pong):
  - Loading continues into the free bank while the other bank is presented.
  - in_ready=0 only when both banks hold complete pairs not yet handed off.
  - Banks are presented in fill order. pair_cnt follows presentation order.
  - Back-to-back: when the last B beat and a mat handshake happen in the same cycle, the new pair shows with mat_valid=1 on the next cycle, with no bubble.
  - Best-case throughput is one pair per 2*M_SIZE*M_SIZE cycles.
  - clear empties both banks.
- Undefined: single bank, exactly the base state machine above.

Decomposition:
- mmac_pkg additions:
  - typedef enum loader_state_t {LOAD_A, LOAD_B, PRESENT}.
  - localparam ELEMS = M_SIZE*M_SIZE.
  - function pack_idx(r,c) giving the bit offset.
  - The existing DATA_WIDTH, VAR_WIDTH and M_SIZE.
- One sub-module, mmac_operand_bank: one A/B register pair with a write port (sel, idx, data) and packed read buses. Instantiated once, or twice under MMAC_LOADER_DBUF_EN.

Test Plan:
- Reset then stream A=1..16 and B=16..1 with mat_ready=1:
  - mat_valid rises 1 cycle after beat 32.
  - matrixA bits[7:0]=1 and bits[127:120]=16.
  - mat_first=1, group_cnt=0.
- Hold mat_ready=0 for 10 cycles after mat_valid:
  - Outputs stable; in_ready=0 (base build).
  - Raise mat_ready: a single handshake occurs, then in_ready=1 the next cycle.
- Five consecutive pairs with ACC_DEPTH=4: group_cnt sequence 0,1,2,3,0; mat_first high on pairs 1 and 5.
- Assert clear after beat 20 and again while mat_valid=1:
  - mat_valid drops.
  - The next 32 beats form a fresh pair with mat_first=1.
  - The beat offered with clear is not accepted.
- reset=0 for one cycle mid-LOAD_B with in_valid held high:
  - All outputs return to reset values.
  - No beat is accepted that cycle.
  - A full 32-beat reload produces a correct pair.
- With MMAC_LOADER_DBUF_EN, in_valid=1 and mat_ready=1 continuously:
  - One mat handshake every 32 cycles in steady state.
  - in_ready never deasserts.
  - Pair data matches fill order.
